// File: rtl/difftest_step_pkg.sv
// Shared state encoding and default sizing for the difftest step batcher.
// Optional idle-timeout flush is enabled with DIFFTEST_STEP_TIMEOUT_EN.
package difftest_step_pkg;

   localparam int unsigned DEF_STEP_WIDTH = 8;
   localparam int unsigned DEF_NCOMMIT    = 6;
   localparam int unsigned DEF_BATCH_SIZE = 64;
   localparam int unsigned DEF_TIMEOUT    = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_HALT
   } step_state_e;

endpackage

// File: rtl/difftest_step_batcher_popcount.sv
// Combinational population count of the per-cycle commit valid bits.
module difftest_popcount #(
   parameter int unsigned NCOMMIT = 6,
   parameter int unsigned CNT_W   = $clog2(NCOMMIT + 1)
) (
   input  logic [NCOMMIT-1:0] commit_valid,
   output logic [CNT_W-1:0]   count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < NCOMMIT; i++) begin
         count = count + CNT_W'(commit_valid[i]);
      end
   end

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches committed instructions into difftest step pulses; trap forces a final flush.
// Define DIFFTEST_STEP_TIMEOUT_EN to flush partial batches after TIMEOUT idle cycles.
module difftest_step_batcher
   import difftest_step_pkg::*;
#(
   parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH,
   parameter int unsigned NCOMMIT    = DEF_NCOMMIT,
   parameter int unsigned BATCH_SIZE = DEF_BATCH_SIZE,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NCOMMIT-1:0]    commit_valid,
   input  logic                  trap_valid,
   output logic [STEP_WIDTH-1:0] difftest_step,
   output logic                  halted,
   output logic [63:0]           total_steps
);

   localparam int unsigned CNT_W = $clog2(NCOMMIT + 1);
   localparam longint unsigned STEP_MAX = (64'd1 << STEP_WIDTH) - 64'd1;
   localparam logic [STEP_WIDTH-1:0] BATCH_THR = STEP_WIDTH'(BATCH_SIZE);

   // acc never exceeds BATCH_SIZE-1, so acc_next fits STEP_WIDTH when this holds.
   if ((64'(BATCH_SIZE) + 64'(NCOMMIT) - 64'd1 > STEP_MAX) || BATCH_SIZE == 0 || TIMEOUT == 0)
   begin : g_bad_params
      $error("difftest_step_batcher: illegal BATCH_SIZE/NCOMMIT/STEP_WIDTH/TIMEOUT");
   end

   step_state_e           state;
   logic [STEP_WIDTH-1:0] acc;
   logic [STEP_WIDTH-1:0] acc_next;
   logic [CNT_W-1:0]      n;
   logic                  batch_hit;
   logic                  timeout_hit;

   difftest_popcount #(
      .NCOMMIT (NCOMMIT),
      .CNT_W   (CNT_W)
   ) u_popcount (
      .commit_valid (commit_valid),
      .count        (n)
   );

   assign acc_next  = acc + STEP_WIDTH'(n);
   assign batch_hit = (acc_next >= BATCH_THR);

`ifdef DIFFTEST_STEP_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic [IDLE_W-1:0] idle_next;
   logic              idle_cycle;

   always_comb begin
      idle_cycle  = (state == ST_ACCUM) && (n == '0);
      idle_next   = idle_cycle ? idle_cnt + IDLE_W'(1) : '0;
      timeout_hit = idle_cycle && (idle_next == IDLE_W'(TIMEOUT));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idle_cnt <= '0;
      end else if (state == ST_HALT || trap_valid || batch_hit || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_next;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         acc           <= '0;
         difftest_step <= '0;
         halted        <= 1'b0;
         total_steps   <= '0;
      end else begin
         difftest_step <= '0;
         case (state)
            ST_HALT: begin
               halted <= 1'b1;
            end
            default: begin
               // Trap wins over batch/timeout; its flush carries this cycle's commits.
               if (trap_valid) begin
                  difftest_step <= acc_next;
                  total_steps   <= total_steps + 64'(acc_next);
                  acc           <= '0;
                  halted        <= 1'b1;
                  state         <= ST_HALT;
               end else if (batch_hit || timeout_hit) begin
                  difftest_step <= acc_next;
                  total_steps   <= total_steps + 64'(acc_next);
                  acc           <= '0;
                  state         <= ST_IDLE;
               end else begin
                  acc   <= acc_next;
                  state <= (acc_next == '0) ? ST_IDLE : ST_ACCUM;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher; timeout expectations follow DIFFTEST_STEP_TIMEOUT_EN.
module tb_difftest_step_batcher;

   logic        clock;
   logic        reset;
   logic [5:0]  commit_valid;
   logic        trap_valid;
   logic [7:0]  difftest_step;
   logic        halted;
   logic [63:0] total_steps;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [5:0]  cv;
      logic        trap;
      logic [7:0]  step;
      logic        halted;
      logic [63:0] total;
   } vec_t;

   vec_t vecs[$];

   difftest_step_batcher #(
      .STEP_WIDTH (8),
      .NCOMMIT    (6),
      .BATCH_SIZE (64),
      .TIMEOUT    (16)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .commit_valid  (commit_valid),
      .trap_valid    (trap_valid),
      .difftest_step (difftest_step),
      .halted        (halted),
      .total_steps   (total_steps)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string name, input logic [7:0] st, input logic h, input logic [63:0] tot);
      chk({name, ".step"},   64'(difftest_step), 64'(st));
      chk({name, ".halted"}, 64'(halted),        64'(h));
      chk({name, ".total"},  total_steps,        tot);
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic [5:0] cv, input logic trap);
      commit_valid = cv;
      trap_valid   = trap;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      commit_valid = '0;
      trap_valid   = 1'b0;
      @(posedge clock);
      #1;
      chk_outs("reset", 8'd0, 1'b0, 64'd0);
      reset = 1'b1;
   endtask

   function automatic void add(input logic [5:0] cv, input logic trap, input logic [7:0] st,
                               input logic h, input logic [63:0] tot);
      vec_t v;
      v.cv = cv; v.trap = trap; v.step = st; v.halted = h; v.total = tot;
      vecs.push_back(v);
   endfunction

   initial begin
      reset        = 1'b0;
      commit_valid = '0;
      trap_valid   = 1'b0;

      // 11 full cycles -> 66; then 60+3 (no emit at 63), +1 -> 64; idle; trap with 3 -> 133.
      for (int i = 0; i < 10; i++) add(6'h3F, 1'b0, 8'd0, 1'b0, 64'd0);
      add(6'h3F, 1'b0, 8'd66, 1'b0, 64'd66);
      for (int i = 0; i < 10; i++) add(6'h3F, 1'b0, 8'd0, 1'b0, 64'd66);
      add(6'h07, 1'b0, 8'd0,  1'b0, 64'd66);
      add(6'h01, 1'b0, 8'd64, 1'b0, 64'd130);
      add(6'h00, 1'b0, 8'd0,  1'b0, 64'd130);
      add(6'h07, 1'b1, 8'd3,  1'b1, 64'd133);
      for (int i = 0; i < 3; i++) add(6'h3F, 1'b1, 8'd0, 1'b1, 64'd133);
      for (int i = 0; i < 3; i++) add(6'h3F, 1'b0, 8'd0, 1'b1, 64'd133);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].cv, vecs[i].trap);
         chk_outs($sformatf("vec%0d", i), vecs[i].step, vecs[i].halted, vecs[i].total);
      end

      // acc=10, trap with 3 same-cycle commits -> 13, then halted; async reset clears halted.
      do_reset();
      cyc(6'h3F, 1'b0);
      cyc(6'h0F, 1'b0);
      chk_outs("trap_pre", 8'd0, 1'b0, 64'd0);
      cyc(6'h07, 1'b1);
      chk_outs("trap_emit", 8'd13, 1'b1, 64'd13);
      cyc(6'h3F, 1'b0);
      chk_outs("trap_after", 8'd0, 1'b1, 64'd13);
      #1 reset = 1'b0;
      #1;
      chk_outs("halt_async_rst", 8'd0, 1'b0, 64'd0);
      reset = 1'b1;

      // Trap with nothing accumulated still flushes (step 0) and halts.
      do_reset();
      cyc(6'h00, 1'b1);
      chk_outs("trap_zero", 8'd0, 1'b1, 64'd0);

      // Trap beats a simultaneous batch threshold: 60 + 6 emitted as one flush.
      do_reset();
      for (int i = 0; i < 10; i++) cyc(6'h3F, 1'b0);
      cyc(6'h3F, 1'b1);
      chk_outs("trap_prio", 8'd66, 1'b1, 64'd66);

      // 5 commits then idle: timeout flush at the 16th idle cycle only when enabled.
      do_reset();
      cyc(6'h1F, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         cyc(6'h00, 1'b0);
`ifdef DIFFTEST_STEP_TIMEOUT_EN
         chk($sformatf("idle%0d", i), 64'(difftest_step), (i == 16) ? 64'd5 : 64'd0);
`else
         chk($sformatf("idle%0d", i), 64'(difftest_step), 64'd0);
`endif
      end
`ifdef DIFFTEST_STEP_TIMEOUT_EN
      chk("idle_total", total_steps, 64'd5);
`else
      chk("idle_total", total_steps, 64'd0);
`endif

      // Reset at acc=40 discards the partial batch; 64 fresh commits emit 64.
      do_reset();
      for (int i = 0; i < 11; i++) cyc(6'h3F, 1'b0);
      chk_outs("pre_batch", 8'd66, 1'b0, 64'd66);
      for (int i = 0; i < 6; i++) cyc(6'h3F, 1'b0);
      cyc(6'h0F, 1'b0);
      chk_outs("acc40", 8'd0, 1'b0, 64'd66);
      #1 reset = 1'b0;
      #1;
      chk_outs("async_rst", 8'd0, 1'b0, 64'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(6'h3F, 1'b0);
         chk($sformatf("post_rst%0d", i), 64'(difftest_step), 64'd0);
      end
      cyc(6'h0F, 1'b0);
      chk_outs("post_rst_emit", 8'd64, 1'b0, 64'd64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/difftest_step_batcher.md
DIFFTEST_STEP_BATCHER -- requirements
Module: difftest_step_batcher

Interface
REQ-001 SHALL have parameter STEP_WIDTH, default 8: width of the emitted step count.
REQ-002 SHALL have parameter NCOMMIT, default 6: number of per-cycle commit ports.
REQ-003 SHALL have parameter BATCH_SIZE, default 64: accumulated-commit threshold that forces an emit.
REQ-004 SHALL have parameter TIMEOUT, default 16: idle cycles before a partial batch is emitted.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low (asserted at 0).
REQ-007 SHALL have port commit_valid, input, NCOMMIT: one bit per instruction committed this cycle.
REQ-008 SHALL have port trap_valid, input, 1: core hit a trap this cycle; final flush.
REQ-009 SHALL have port difftest_step, output, STEP_WIDTH: registered count of instructions the checker advances this cycle; 0 means no step.
REQ-010 SHALL have port halted, output, 1: high once the trap flush has been emitted.
REQ-011 SHALL have port total_steps, output, 64: running sum of all emitted step counts.

Function
REQ-012 SHALL compute n = popcount(commit_valid) and acc_next = acc + n each cycle.
REQ-013 SHALL implement states IDLE (acc==0), ACCUM (acc>0) and HALT.
REQ-014 In IDLE/ACCUM, if acc_next >= BATCH_SIZE, SHALL drive difftest_step=acc_next on the next cycle, clear acc, and go to IDLE.
REQ-015 In IDLE/ACCUM, if trap_valid, SHALL include the same-cycle commits, drive difftest_step=acc_next on the next cycle (including when acc_next==0), clear acc, and go to HALT.
REQ-016 trap_valid SHALL take priority over the batch and timeout triggers; only one emit occurs per cycle.
REQ-017 Otherwise, SHALL store acc_next and drive difftest_step=0; state is IDLE if acc_next==0, else ACCUM.
REQ-018 difftest_step SHALL be a one-cycle pulse with latency exactly 1 cycle after the triggering cycle.
REQ-019 In HALT, SHALL ignore commit_valid and trap_valid, hold difftest_step=0, and hold halted=1 until reset.
REQ-020 total_steps SHALL add each emitted value in the cycle difftest_step is driven, and SHALL wrap modulo 2^64.
REQ-021 Legal parameters SHALL satisfy BATCH_SIZE+NCOMMIT-1 <= 2^STEP_WIDTH-1; elaboration SHALL fail otherwise.

Reset
REQ-022 On reset=0, SHALL immediately force difftest_step=0, halted=0, total_steps=0, acc=0, idle counter=0, state=IDLE.
REQ-023 Reset during ACCUM SHALL discard the partial batch with no emit; counting restarts from 0 after release.

Configuration
REQ-024 With DIFFTEST_STEP_TIMEOUT_EN defined, an idle counter SHALL increment on each ACCUM cycle with n==0 and clear on any commit.
REQ-025 With DIFFTEST_STEP_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT, SHALL emit acc next cycle and go to IDLE.
REQ-026 Without DIFFTEST_STEP_TIMEOUT_EN, SHALL contain no idle counter; emits occur only per REQ-014 and REQ-015.

Structure
REQ-027 SHALL place the state enum and default STEP_WIDTH/BATCH_SIZE/TIMEOUT constants in shared package difftest_step_pkg.
REQ-028 SHALL implement the popcount in sub-module difftest_popcount (parameter NCOMMIT, purely combinational).

Verification (NCOMMIT=6, BATCH_SIZE=64, TIMEOUT=16, STEP_WIDTH=8)
REQ-029 SHALL cover: commit_valid=6'h3F for 11 cycles -> difftest_step 0 for 10 cycles, 66 in the cycle after the 11th; acc=0.
REQ-030 SHALL cover: acc=10, then trap_valid with commit_valid=6'h07 -> difftest_step=13 next cycle, halted=1; further commits give step 0.
REQ-031 SHALL cover: 5 commits then idle -> with the macro, step=5 after 16 idle cycles; without the macro, step stays 0 for 100 cycles.
REQ-032 SHALL cover: reset=0 at acc=40 -> all outputs 0 asynchronously; after release, 64 commits emit 64 (not 104).
REQ-033 SHALL cover: batches of 66, 64, then trap with 3 -> total_steps=133, and it never changes after halted=1.
